// File: rtl/fc_ip_feeder.sv
// fc_ip_feeder: operand sequencer feeding the FC-layer MAC (bias, data/weight pairs, neuron done).
// Define FC_STALL_CNT_EN to add stall_cnt_o, a saturating count of stream-stall cycles.
module fc_ip_feeder #(
   parameter int FW    = 32,
   parameter int INN_W = 13,
   parameter int ONN_W = 13
) (
   input  logic             clk_i,
   input  logic             rstn_i,
   input  logic             start_i,
   input  logic [INN_W-1:0] inn_i,
   input  logic [ONN_W-1:0] onn_i,
   output logic             ibuf_rd_o,
   output logic [INN_W-1:0] ibuf_addr_o,
   input  logic [FW-1:0]    ibuf_data_i,
   input  logic [FW-1:0]    wt_data_i,
   input  logic             wt_valid_i,
   output logic             wt_ready_o,
   input  logic [FW-1:0]    bias_data_i,
   input  logic             bias_valid_i,
   output logic             bias_ready_o,
   output logic [FW-1:0]    ip_data_o,
   output logic             ip_data_valid_o,
   output logic             ip_weight_valid_o,
   output logic [FW-1:0]    ip_weight_o,
   output logic [FW-1:0]    ip_bias_o,
   output logic             ip_bias_valid_o,
   output logic             ip_oneuron_done_o,
   output logic             busy_o,
`ifdef FC_STALL_CNT_EN
   output logic [31:0]      stall_cnt_o,
`endif
   output logic             done_o
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_BIAS,
      S_MAC,
      S_LAST,
      S_DONE,
      S_DRAIN
   } state_t;

   state_t           state_q, state_d;
   logic [INN_W-1:0] k_q, k_d;
   logic [ONN_W-1:0] n_q, n_d;
   logic [FW-1:0]    bias_q, bias_d;
   logic [FW-1:0]    weight_q, weight_d;
   logic             bias_vld_q, bias_vld_d;
   logic             op_vld_q, op_vld_d;
   logic             done_q, done_d;

   logic [INN_W-1:0] inn_last;
   logic [ONN_W-1:0] onn_last;
   logic             size_zero;

   assign inn_last  = inn_i - 1'b1;
   assign onn_last  = onn_i - 1'b1;
   assign size_zero = (inn_i == '0) || (onn_i == '0);

   always_comb begin
      state_d           = state_q;
      k_d               = k_q;
      n_d               = n_q;
      bias_d            = bias_q;
      weight_d          = weight_q;
      bias_vld_d        = 1'b0;
      op_vld_d          = 1'b0;
      done_d            = 1'b0;
      wt_ready_o        = 1'b0;
      bias_ready_o      = 1'b0;
      ibuf_rd_o         = 1'b0;
      ip_oneuron_done_o = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               if (size_zero) begin
                  done_d = 1'b1;
               end else begin
                  n_d     = '0;
                  k_d     = '0;
                  state_d = S_BIAS;
               end
            end
         end

         S_BIAS: begin
            bias_ready_o = 1'b1;
            if (bias_valid_i) begin
               bias_d     = bias_data_i;
               bias_vld_d = 1'b1;
               state_d    = S_MAC;
            end
         end

         S_MAC: begin
            wt_ready_o = 1'b1;
            if (wt_valid_i) begin
               ibuf_rd_o = 1'b1;
               weight_d  = wt_data_i;
               op_vld_d  = 1'b1;
               if (k_q == inn_last) begin
                  state_d = S_LAST;
               end else begin
                  k_d = k_q + 1'b1;
               end
            end
         end

         S_LAST: begin
            state_d = S_DONE;
         end

         // done_o is registered here so it lands in the DRAIN cycle, like the zero-size pulse
         S_DONE: begin
            ip_oneuron_done_o = 1'b1;
            done_d            = (n_q == onn_last);
            state_d           = S_DRAIN;
         end

         S_DRAIN: begin
            if (n_q != onn_last) begin
               n_d     = n_q + 1'b1;
               k_d     = '0;
               state_d = S_BIAS;
            end else begin
               state_d = S_IDLE;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q    <= S_IDLE;
         k_q        <= '0;
         n_q        <= '0;
         bias_q     <= '0;
         weight_q   <= '0;
         bias_vld_q <= 1'b0;
         op_vld_q   <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         k_q        <= k_d;
         n_q        <= n_d;
         bias_q     <= bias_d;
         weight_q   <= weight_d;
         bias_vld_q <= bias_vld_d;
         op_vld_q   <= op_vld_d;
         done_q     <= done_d;
      end
   end

   assign ibuf_addr_o       = k_q;
   assign ip_data_o         = ibuf_data_i;
   assign ip_data_valid_o   = op_vld_q;
   assign ip_weight_valid_o = op_vld_q;
   assign ip_weight_o       = weight_q;
   assign ip_bias_o         = bias_q;
   assign ip_bias_valid_o   = bias_vld_q;
   assign busy_o            = (state_q != S_IDLE);
   assign done_o            = done_q;

`ifdef FC_STALL_CNT_EN
   logic [31:0] stall_cnt_q, stall_cnt_d;
   logic        stall_evt;

   assign stall_evt = ((state_q == S_MAC) && !wt_valid_i) ||
                      ((state_q == S_BIAS) && !bias_valid_i);

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if ((state_q == S_IDLE) && start_i) begin
         stall_cnt_d = '0;
      end else if (stall_evt && (stall_cnt_q != '1)) begin
         stall_cnt_d = stall_cnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         stall_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign stall_cnt_o = stall_cnt_q;
`endif

endmodule
